raster_stream_gen: RTL



---
 rtl/raster_pkg.sv | 38 +++
 rtl/raster_wrap_cnt.sv | 46 ++++
 rtl/raster_stream_gen.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// -----------------------------------------------------------------------------
// raster_pkg
// Shared definitions for the raster stream generator:
//   raster_state_t : frame sequencing states (IDLE, ACTIVE, HBLANK, VBLANK)
//   STALL_CNT_W    : width of the optional saturating stall counter
//   cnt_w()        : bits needed to count 0..n-1 (never less than 1)
//   max_u()        : larger of two unsigned values
// -----------------------------------------------------------------------------
package raster_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } raster_state_t;

    localparam int unsigned STALL_CNT_W = 16;

    // Bits required to hold the values 0..n-1; a zero or one-entry range still
    // gets a one-bit counter so every instance has a legal width.
    function automatic int unsigned cnt_w(input int unsigned n);
        if (n <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/raster_wrap_cnt.sv
// -----------------------------------------------------------------------------
// raster_wrap_cnt
// Up-counter that wraps to zero after reaching a run-time terminal value.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, has priority over en
//   en    : advance by one (or wrap when at terminal value)
//   last  : terminal value
//   count : current value
//   tc    : count == last
// -----------------------------------------------------------------------------
module raster_wrap_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_r;

    assign count = count_r;
    assign tc    = (count_r == last);

    // Counter register: clear, then wrap-or-increment when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (en) begin
            if (tc) begin
                count_r <= {W{1'b0}};
            end else begin
                count_r <= count_r + W'(1'b1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/raster_stream_gen.sv
// -----------------------------------------------------------------------------
// raster_stream_gen
// Turns a valid/ready pixel stream into raster-timed video: WIDTH pixels per
// line, H_BLANK idle cycles after each line, HEIGHT lines, then V_BLANK blank
// lines of WIDTH+H_BLANK cycles, then a one-cycle frame_done pulse.
//
// Ports:
//   clk, rst            : clock; asynchronous active-low reset
//   start               : begin one frame (only looked at in IDLE)
//   in_valid / in_ready : source handshake; in_ready only in ACTIVE
//   r_in, g_in, b_in    : source pixel
//   out_valid           : registered output pixel is active video
//   h_count_out         : column of output pixel (holds when not valid)
//   v_count_out         : line of output pixel (holds when not valid)
//   r_out, g_out, b_out : registered pixel, zero when not valid
//   frame_done          : one-cycle pulse after the last blank cycle
//   busy                : FSM is not IDLE
//
// Optional build macro RASTER_GEN_UNDERRUN_EN adds:
//   underrun  : sticky flag, set by any ACTIVE cycle without in_valid
//   stall_cnt : saturating count of such cycles
//   Both clear when a start is taken in IDLE.
// -----------------------------------------------------------------------------
module raster_stream_gen
    import raster_pkg::*;
#(
    parameter int unsigned P_IMGDEPTH = 8,
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned H_BLANK    = 16,
    parameter int unsigned V_BLANK    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [P_IMGDEPTH-1:0]         r_in,
    input  logic [P_IMGDEPTH-1:0]         g_in,
    input  logic [P_IMGDEPTH-1:0]         b_in,
    output logic                          out_valid,
    output logic [$clog2(WIDTH+1)-1:0]    h_count_out,
    output logic [$clog2(HEIGHT+1)-1:0]   v_count_out,
    output logic [P_IMGDEPTH-1:0]         r_out,
    output logic [P_IMGDEPTH-1:0]         g_out,
    output logic [P_IMGDEPTH-1:0]         b_out,
    output logic                          frame_done,
    output logic                          busy
`ifdef RASTER_GEN_UNDERRUN_EN
    ,
    output logic                          underrun,
    output logic [STALL_CNT_W-1:0]        stall_cnt
`endif
);

    localparam int unsigned HW     = $clog2(WIDTH + 1);
    localparam int unsigned VW     = $clog2(HEIGHT + 1);
    localparam int unsigned VB_CYC = V_BLANK * (WIDTH + H_BLANK);
    localparam int unsigned BW     = cnt_w(max_u(H_BLANK, VB_CYC));

    localparam logic [HW-1:0] H_LAST  = HW'(WIDTH - 32'd1);
    localparam logic [VW-1:0] V_LAST  = VW'(HEIGHT - 32'd1);
    localparam logic [BW-1:0] HB_LAST = BW'((H_BLANK > 32'd0) ? (H_BLANK - 32'd1) : 32'd0);
    localparam logic [BW-1:0] VB_LAST = BW'((VB_CYC > 32'd0) ? (VB_CYC - 32'd1) : 32'd0);
    localparam bit            HB_EN   = (H_BLANK != 32'd0);
    localparam bit            VB_EN   = (V_BLANK != 32'd0);

    raster_state_t state_r;
    raster_state_t state_next_s;
    raster_state_t exit_tgt_s;

    logic          idle_s;
    logic          accept_s;
    logic          line_end_s;
    logic          hb_exit_s;
    logic          vb_exit_s;
    logic          done_s;
    logic          v_inc_s;
    logic          blank_en_s;
    logic [BW-1:0] blank_last_s;

    logic [HW-1:0] h_cnt_s;
    logic          h_tc_s;
    logic [VW-1:0] v_cnt_s;
    logic          v_tc_s;
    logic [BW-1:0] blank_cnt_unused_s;
    logic          blank_tc_s;

    logic                  out_valid_r;
    logic [HW-1:0]         h_out_r;
    logic [VW-1:0]         v_out_r;
    logic [P_IMGDEPTH-1:0] r_out_r;
    logic [P_IMGDEPTH-1:0] g_out_r;
    logic [P_IMGDEPTH-1:0] b_out_r;
    logic                  frame_done_r;

    // Column counter: advances on each accepted pixel, wraps at end of line.
    raster_wrap_cnt #(.W(HW)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (idle_s),
        .en    (accept_s),
        .last  (H_LAST),
        .count (h_cnt_s),
        .tc    (h_tc_s)
    );

    // Line counter: advances when a line's blanking ends and more lines remain.
    raster_wrap_cnt #(.W(VW)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (idle_s | done_s),
        .en    (v_inc_s),
        .last  (V_LAST),
        .count (v_cnt_s),
        .tc    (v_tc_s)
    );

    // Blank counter shared by HBLANK and VBLANK; it wraps to zero on the
    // exit cycle of each blanking period, so VBLANK starts from zero.
    raster_wrap_cnt #(.W(BW)) u_blank_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (idle_s),
        .en    (blank_en_s),
        .last  (blank_last_s),
        .count (blank_cnt_unused_s),
        .tc    (blank_tc_s)
    );

    // Datapath control decodes derived from the current state and counters.
    always_comb begin
        idle_s     = (state_r == IDLE);
        accept_s   = (state_r == ACTIVE) && in_valid;
        line_end_s = accept_s && h_tc_s;
        blank_en_s = (state_r == HBLANK) || (state_r == VBLANK);
        if (state_r == VBLANK) begin
            blank_last_s = VB_LAST;
        end else begin
            blank_last_s = HB_LAST;
        end
        // With no horizontal blanking the end-of-line accept is the HBLANK exit.
        hb_exit_s = ((state_r == HBLANK) && blank_tc_s) || (!HB_EN && line_end_s);
        vb_exit_s = (state_r == VBLANK) && blank_tc_s;
        done_s    = vb_exit_s || (hb_exit_s && v_tc_s && !VB_EN);
        v_inc_s   = hb_exit_s && !v_tc_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        if (!v_tc_s) begin
            exit_tgt_s = ACTIVE;
        end else if (VB_EN) begin
            exit_tgt_s = VBLANK;
        end else begin
            exit_tgt_s = IDLE;
        end
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = ACTIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACTIVE: begin
                if (line_end_s) begin
                    if (HB_EN) begin
                        state_next_s = HBLANK;
                    end else begin
                        state_next_s = exit_tgt_s;
                    end
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            HBLANK: begin
                if (blank_tc_s) begin
                    state_next_s = exit_tgt_s;
                end else begin
                    state_next_s = HBLANK;
                end
            end
            VBLANK: begin
                if (blank_tc_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = VBLANK;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output pixel register: capture on accept, otherwise zero data and hold position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r  <= 1'b0;
            h_out_r      <= {HW{1'b0}};
            v_out_r      <= {VW{1'b0}};
            r_out_r      <= {P_IMGDEPTH{1'b0}};
            g_out_r      <= {P_IMGDEPTH{1'b0}};
            b_out_r      <= {P_IMGDEPTH{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= done_s;
            if (accept_s) begin
                out_valid_r <= 1'b1;
                h_out_r     <= h_cnt_s;
                v_out_r     <= v_cnt_s;
                r_out_r     <= r_in;
                g_out_r     <= g_in;
                b_out_r     <= b_in;
            end else begin
                out_valid_r <= 1'b0;
                h_out_r     <= h_out_r;
                v_out_r     <= v_out_r;
                r_out_r     <= {P_IMGDEPTH{1'b0}};
                g_out_r     <= {P_IMGDEPTH{1'b0}};
                b_out_r     <= {P_IMGDEPTH{1'b0}};
            end
        end
    end

    assign in_ready    = (state_r == ACTIVE);
    assign busy        = (state_r != IDLE);
    assign out_valid   = out_valid_r;
    assign h_count_out = h_out_r;
    assign v_count_out = v_out_r;
    assign r_out       = r_out_r;
    assign g_out       = g_out_r;
    assign b_out       = b_out_r;
    assign frame_done  = frame_done_r;

`ifdef RASTER_GEN_UNDERRUN_EN
    logic                   underrun_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    // Underrun tracking: cleared by a taken start, set by ACTIVE cycles without data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_r  <= 1'b0;
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (idle_s && start) begin
            underrun_r  <= 1'b0;
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if ((state_r == ACTIVE) && !in_valid) begin
            underrun_r <= 1'b1;
            if (stall_cnt_r != {STALL_CNT_W{1'b1}}) begin
                stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1'b1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end else begin
            underrun_r  <= underrun_r;
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign underrun  = underrun_r;
    assign stall_cnt = stall_cnt_r;
`endif

endmodule
